pong_video_timing: RTL and testbench

- Sequencer for the Pong horizontal/vertical sync datapath.
- Owns the H and V counters and produces, all registered and mutually coherent:
  - the counter bits;
  - the `_hreset`/`_vreset` terminal-count strobes;
  - the blank and sync windows.
- Replaces the ripple-counter-plus-latch timing and its clock-gating hack with a single synchronous design on `mclk`, advanced by a pixel clock enable.
- Feeds hblank/hsync consumers, vertical logic, and the video mixer.

---
 rtl/pong_timing_pkg.sv | 27 ++
 rtl/timing_axis.sv | 74 +++++++
 rtl/pong_video_timing.sv | 87 ++++++++
 tb/tb_pong_video_timing.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_timing_pkg.sv
// Shared constants and types for the Pong horizontal/vertical timing chain.
package pong_timing_pkg;

  // Both counters are 9 bits wide, so a single axis never exceeds 512 counts.
  localparam int unsigned COUNT_W   = 9;
  localparam int unsigned MAX_TOTAL = 512;

  typedef logic [COUNT_W-1:0] count_t;

  // Default horizontal timing, in pixel clocks.
  localparam int unsigned DEF_H_TOTAL      = 455;
  localparam int unsigned DEF_H_SYNC_START = 32;
  localparam int unsigned DEF_H_SYNC_END   = 64;
  localparam int unsigned DEF_H_BLANK_END  = 80;

  // Default vertical timing, in lines.
  localparam int unsigned DEF_V_TOTAL      = 262;
  localparam int unsigned DEF_V_SYNC_START = 4;
  localparam int unsigned DEF_V_SYNC_END   = 8;
  localparam int unsigned DEF_V_BLANK_END  = 16;

  // Half-open window test: lo <= c < hi, unsigned.
  function automatic logic in_window(input count_t c, input count_t lo, input count_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One timing axis: a wrapping counter with enable plus registered blank and
// sync decodes. Every decode is taken from the next-state count so it lands
// in the same edge as the count itself.
module timing_axis
  import pong_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = DEF_H_TOTAL,
  parameter int unsigned SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned SYNC_END   = DEF_H_SYNC_END,
  parameter int unsigned BLANK_END  = DEF_H_BLANK_END
) (
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_en,
  output count_t o_count,
  output logic   o_next_tc,
  output logic   o_blank,
  output logic   o_blank_n,
  output logic   o_sync_n
);

  // Window ordering must hold and the count must fit in 9 bits.
  if (!((SYNC_START < SYNC_END) && (SYNC_END <= BLANK_END) &&
        (BLANK_END < TOTAL) && (TOTAL <= MAX_TOTAL))) begin : g_bad_params
    $error("timing_axis: illegal window/total parameters");
  end

  localparam count_t C_LAST       = count_t'(TOTAL - 1);
  localparam count_t C_SYNC_START = count_t'(SYNC_START);
  localparam count_t C_SYNC_END   = count_t'(SYNC_END);
  localparam count_t C_BLANK_END  = count_t'(BLANK_END);

  count_t r_count;
  logic   r_blank;
  logic   r_blank_n;
  logic   r_sync_n;
  count_t w_next;

  // Next count: hold when disabled, wrap from the last count to zero.
  always_comb begin
    w_next = r_count;
    if (i_en) begin
      if (r_count == C_LAST) begin
        w_next = '0;
      end else begin
        w_next = r_count + count_t'(1);
      end
    end
  end

  // Terminal count of the value that will be visible after this edge.
  assign o_next_tc = (w_next == C_LAST);

  // Count and decoded windows register together from the next-state count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count   <= '0;
      r_blank   <= 1'b1;
      r_blank_n <= 1'b0;
      r_sync_n  <= 1'b1;
    end else begin
      r_count   <= w_next;
      r_blank   <= (w_next < C_BLANK_END);
      r_blank_n <= !(w_next < C_BLANK_END);
      r_sync_n  <= !in_window(w_next, C_SYNC_START, C_SYNC_END);
    end
  end

  assign o_count   = r_count;
  assign o_blank   = r_blank;
  assign o_blank_n = r_blank_n;
  assign o_sync_n  = r_sync_n;

endmodule

// File: rtl/pong_video_timing.sv
// Pong H/V timing sequencer: two synchronous axes on mclk advanced by the
// pixel enable, with registered line/frame terminal strobes.
module pong_video_timing
  import pong_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_END   = DEF_H_SYNC_END,
  parameter int unsigned H_BLANK_END  = DEF_H_BLANK_END,
  parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_END   = DEF_V_SYNC_END,
  parameter int unsigned V_BLANK_END  = DEF_V_BLANK_END
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       clk7_159,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       _hreset,
  output logic       _vreset,
  output logic       hblank,
  output logic       _hblank,
  output logic       _hsync,
  output logic       vblank,
  output logic       _vblank,
  output logic       _vsync
);

  logic r_hreset_n;
  logic r_vreset_n;
  logic w_h_next_tc;
  logic w_v_next_tc;
  logic w_v_en;

  // r_hreset_n is low exactly while hcnt sits on its last count, so this
  // enable fires only on the pixel edge where the line wraps.
  assign w_v_en = clk7_159 & ~r_hreset_n;

  timing_axis #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END),
    .BLANK_END  (H_BLANK_END)
  ) u_h_axis (
    .i_clk     (mclk),
    .i_reset   (reset),
    .i_en      (clk7_159),
    .o_count   (hcnt),
    .o_next_tc (w_h_next_tc),
    .o_blank   (hblank),
    .o_blank_n (_hblank),
    .o_sync_n  (_hsync)
  );

  timing_axis #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END),
    .BLANK_END  (V_BLANK_END)
  ) u_v_axis (
    .i_clk     (mclk),
    .i_reset   (reset),
    .i_en      (w_v_en),
    .o_count   (vcnt),
    .o_next_tc (w_v_next_tc),
    .o_blank   (vblank),
    .o_blank_n (_vblank),
    .o_sync_n  (_vsync)
  );

  // Terminal strobes from next-state counts; vcnt cannot change on an edge
  // that lands on the last hcnt, so both next-state flags are coherent.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_hreset_n <= 1'b1;
      r_vreset_n <= 1'b1;
    end else begin
      r_hreset_n <= ~w_h_next_tc;
      r_vreset_n <= ~(w_h_next_tc & w_v_next_tc);
    end
  end

  assign _hreset = r_hreset_n;
  assign _vreset = r_vreset_n;

endmodule

// File: tb/tb_pong_video_timing.sv
// Directed bench for pong_video_timing: default-timing instance for line,
// hold and mid-line reset checks; short-line instance for a full frame.
module tb_pong_video_timing;

  logic mclk = 1'b0;
  logic reset = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  logic [8:0] a_hcnt, a_vcnt, b_hcnt, b_vcnt;
  logic a_hreset_n, a_vreset_n, a_hblank, a_hblank_n, a_hsync_n;
  logic a_vblank, a_vblank_n, a_vsync_n;
  logic b_hreset_n, b_vreset_n, b_hblank, b_hblank_n, b_hsync_n;
  logic b_vblank, b_vblank_n, b_vsync_n;

  logic [25:0] obs_a, obs_b;
  assign obs_a = {a_hcnt, a_vcnt, a_hreset_n, a_vreset_n, a_hblank, a_hblank_n,
                  a_hsync_n, a_vblank, a_vblank_n, a_vsync_n};
  assign obs_b = {b_hcnt, b_vcnt, b_hreset_n, b_vreset_n, b_hblank, b_hblank_n,
                  b_hsync_n, b_vblank, b_vblank_n, b_vsync_n};

  int n_vec = 0;
  int n_bad = 0;
  int mh_a = 0, mv_a = 0, mh_b = 0, mv_b = 0;

  // clock/reset block
  always #5 mclk = ~mclk;

  pong_video_timing dut_a (
    .mclk     (mclk),
    .reset    (reset),
    .clk7_159 (en_a),
    .hcnt     (a_hcnt),
    .vcnt     (a_vcnt),
    ._hreset  (a_hreset_n),
    ._vreset  (a_vreset_n),
    .hblank   (a_hblank),
    ._hblank  (a_hblank_n),
    ._hsync   (a_hsync_n),
    .vblank   (a_vblank),
    ._vblank  (a_vblank_n),
    ._vsync   (a_vsync_n)
  );

  pong_video_timing #(
    .H_TOTAL      (10),
    .H_SYNC_START (2),
    .H_SYNC_END   (4),
    .H_BLANK_END  (6)
  ) dut_b (
    .mclk     (mclk),
    .reset    (reset),
    .clk7_159 (en_b),
    .hcnt     (b_hcnt),
    .vcnt     (b_vcnt),
    ._hreset  (b_hreset_n),
    ._vreset  (b_vreset_n),
    .hblank   (b_hblank),
    ._hblank  (b_hblank_n),
    ._hsync   (b_hsync_n),
    .vblank   (b_vblank),
    ._vblank  (b_vblank_n),
    ._vsync   (b_vsync_n)
  );

  // Expected output vector for counts (h, v); vertical windows are 4..7 sync,
  // 0..15 blank, 262 lines.
  function automatic logic [25:0] exp_vec(input int h, input int v, input int ht,
                                          input int hss, input int hse, input int hbe);
    logic hr, vr, hb, hs, vb, vs;
    hr = !(h == ht - 1);
    vr = !((h == ht - 1) && (v == 261));
    hb = (h < hbe);
    hs = !((h >= hss) && (h < hse));
    vb = (v < 16);
    vs = !((v >= 4) && (v < 8));
    return {9'(h), 9'(v), hr, vr, hb, !hb, hs, vb, !vb, vs};
  endfunction

  // Reference counter step for one pixel enable.
  task automatic step(inout int h, inout int v, input int ht);
    if (h == ht - 1) begin
      h = 0;
      v = (v == 261) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: apply enables after the edge, then sample 1ns after the next edge.
  task automatic tick(input logic ea, input logic eb);
    en_a = ea;
    en_b = eb;
    @(posedge mclk);
    #1;
  endtask

  initial begin
    int hr_low;
    int guard;
    int vs_cnt, vb_cnt, vr_cnt, vr_h, vr_v, vs_first, vs_last;

    // Reset state
    #1;
    repeat (3) tick(1'b1, 1'b1);
    chk("rst_vec_a", obs_a, exp_vec(0, 0, 455, 32, 64, 80));
    chk("rst_vec_b", obs_b, exp_vec(0, 0, 10, 2, 4, 6));
    chk("rst_hblank", a_hblank, 1);
    chk("rst_hblank_n", a_hblank_n, 0);
    chk("rst_vreset_n", a_vreset_n, 1);
    reset = 1'b0;

    // One line, enable every 4th mclk
    hr_low = 0;
    for (int k = 1; k <= 455; k++) begin
      tick(1'b1, 1'b0);
      step(mh_a, mv_a, 455);
      if (k == 1) chk("first_release_h", a_hcnt, 1);
      chk("line_vec", obs_a, exp_vec(mh_a, mv_a, 455, 32, 64, 80));
      if (!a_hreset_n) hr_low++;
      case (mh_a)
        31: chk("h31_hsync_n", a_hsync_n, 1);
        32: chk("h32_hsync_n", a_hsync_n, 0);
        63: chk("h63_hsync_n", a_hsync_n, 0);
        64: chk("h64_hsync_n", a_hsync_n, 1);
        79: chk("h79_hblank", a_hblank, 1);
        80: chk("h80_hblank", a_hblank, 0);
        default: ;
      endcase
      for (int j = 0; j < 3; j++) begin
        tick(1'b0, 1'b0);
        chk("line_hold_vec", obs_a, exp_vec(mh_a, mv_a, 455, 32, 64, 80));
        if (!a_hreset_n) hr_low++;
      end
    end
    chk("hreset_low_mclks", hr_low, 4);
    chk("wrap_hcnt", a_hcnt, 0);
    chk("wrap_vcnt", a_vcnt, 1);

    // Hold at hcnt=40 for 100 mclk
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b0);
      step(mh_a, mv_a, 455);
    end
    chk("at40_hcnt", a_hcnt, 40);
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, 1'b0);
      chk("hold_vec", obs_a, exp_vec(40, 1, 455, 32, 64, 80));
    end
    chk("hold_hsync_n", a_hsync_n, 0);

    // Advance to vcnt=5, hcnt=50, then a one-mclk reset with enable low
    guard = 0;
    while (!(mh_a == 50 && mv_a == 5) && guard < 5000) begin
      tick(1'b1, 1'b0);
      step(mh_a, mv_a, 455);
      guard++;
    end
    chk("adv_vec", obs_a, exp_vec(mh_a, mv_a, 455, 32, 64, 80));
    chk("pre_hcnt", a_hcnt, 50);
    chk("pre_vcnt", a_vcnt, 5);
    chk("pre_vsync_n", a_vsync_n, 0);
    chk("pre_hsync_n", a_hsync_n, 0);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    mh_a = 0;
    mv_a = 0;
    chk("mrst_hcnt", a_hcnt, 0);
    chk("mrst_vcnt", a_vcnt, 0);
    chk("mrst_hblank", a_hblank, 1);
    chk("mrst_hsync_n", a_hsync_n, 1);
    chk("mrst_vsync_n", a_vsync_n, 1);
    chk("mrst_hreset_n", a_hreset_n, 1);

    // Full frame on the 10-count-line instance, enable every mclk
    vs_cnt = 0; vb_cnt = 0; vr_cnt = 0; vr_h = -1; vr_v = -1;
    vs_first = 999; vs_last = -1;
    for (int k = 1; k <= 2620; k++) begin
      tick(1'b0, 1'b1);
      step(mh_b, mv_b, 10);
      chk("frame_vec", obs_b, exp_vec(mh_b, mv_b, 10, 2, 4, 6));
      if (k <= 9) chk("short_hsync_n", b_hsync_n, (k == 2 || k == 3) ? 0 : 1);
      if (k <= 9) chk("short_hblank", b_hblank, (k <= 5) ? 1 : 0);
      if (!b_vsync_n) begin
        vs_cnt++;
        if (mv_b < vs_first) vs_first = mv_b;
        if (mv_b > vs_last) vs_last = mv_b;
      end
      if (b_vblank) vb_cnt++;
      if (!b_vreset_n) begin
        vr_cnt++;
        vr_h = b_hcnt;
        vr_v = b_vcnt;
      end
    end
    chk("vsync_enables", vs_cnt, 40);
    chk("vsync_first_line", vs_first, 4);
    chk("vsync_last_line", vs_last, 7);
    chk("vblank_enables", vb_cnt, 160);
    chk("vreset_count", vr_cnt, 1);
    chk("vreset_vcnt", vr_v, 261);
    chk("vreset_hcnt", vr_h, 9);
    chk("frame_end_hcnt", b_hcnt, 0);
    chk("frame_end_vcnt", b_vcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
